uart_rx_core: RTL

Receive half of the team's UART link. It recovers 8N1 frames from the asynchronous SERIAL line using the same CLKDIV bit-period convention as the transmitter: one bit lasts CLKDIV+1 clock cycles. It delivers each byte with a one-cycle DONE strobe. It sits between the board RX pin and the byte-consumer logic, and is the loopback partner of the existing transmitter.

---
 rtl/uart_rx_core.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with CLKDIV bit timing, DONE/FRAME_ERR strobes
module uart_rx_core (
    input  logic        CLK,
    input  logic        SRSTN,
    input  logic        SERIAL,
    input  logic [15:0] CLKDIV,
    output logic [7:0]  DATA,
    output logic        DONE,
    output logic        FRAME_ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    logic        sync1_q;
    logic        rx_s;
    state_t      state_q,   state_d;
    logic [15:0] cntr_q,    cntr_d;
    logic [2:0]  bitcntr_q, bitcntr_d;
    logic [7:0]  shreg_q,   shreg_d;
    logic [15:0] div_q,     div_d;
    logic [7:0]  data_q,    data_d;
    logic        done_q,    done_d;
    logic        ferr_q,    ferr_d;
    logic [15:0] half;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge CLK) begin
        if (!SRSTN) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= SERIAL;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!SRSTN) begin
            state_q   <= S_IDLE;
            cntr_q    <= 16'd0;
            bitcntr_q <= 3'd0;
            shreg_q   <= 8'h00;
            div_q     <= 16'd0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cntr_q    <= cntr_d;
            bitcntr_q <= bitcntr_d;
            shreg_q   <= shreg_d;
            div_q     <= div_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign half = div_q >> 1;

    always_comb begin
        state_d   = state_q;
        cntr_d    = cntr_q;
        bitcntr_d = bitcntr_q;
        shreg_d   = shreg_q;
        div_d     = div_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cntr_d  = 16'd0;
                    div_d   = CLKDIV;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject short glitches
                if (cntr_q == half) begin
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        cntr_d    = 16'd0;
                        bitcntr_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cntr_d = cntr_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cntr_q == div_q) begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    cntr_d    = 16'd0;
                    bitcntr_d = bitcntr_q + 3'd1;
                    if (bitcntr_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cntr_d = cntr_q + 16'd1;
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit lets the next start edge follow with no gap
                if (cntr_q == div_q) begin
                    if (rx_s) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    cntr_d = cntr_q + 16'd1;
                end
            end
            S_WAIT: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign DATA      = data_q;
    assign DONE      = done_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule
